// File: rtl/reg_port_pkg.sv
// rtl/reg_port_pkg.sv - shared state type and widths for reg_port_master (REG_PORT_MASTER_READBACK_EN adds VERIFY)
package reg_port_pkg;

  // Default widths shared with reg_file.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_RESP   = 3'd3
`ifdef REG_PORT_MASTER_READBACK_EN
    ,
    ST_VERIFY = 3'd4
`endif
  } port_state_e;

  // A new request can be taken in IDLE, and while a write is on the bus
  // when read-back checking is off (write pipelining).
  function automatic logic state_accepts(input port_state_e s);
`ifdef REG_PORT_MASTER_READBACK_EN
    return (s == ST_IDLE);
`else
    return (s == ST_IDLE) || (s == ST_WRITE);
`endif
  endfunction

endpackage

// File: rtl/reg_port_tbuf.sv
// rtl/reg_port_tbuf.sv - tristate data bus driver with sample path
module reg_port_tbuf #(
  parameter int W = 16
) (
  input  logic         oe,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);

  // Drive the pad only when enabled; otherwise release it to the register file.
  assign pad = oe ? dout : {W{1'bz}};

  // Whatever is on the pad, ours or the file's, is visible to the sampler.
  assign din = pad;

endmodule

// File: rtl/reg_port_master.sv
// rtl/reg_port_master.sv - request/response master for one reg_file port (REG_PORT_MASTER_READBACK_EN enables write read-back)
module reg_port_master
  import reg_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              wr_err,
  output logic [ADDR_W-1:0] port_addr,
  output logic              port_read,
  inout  wire  [DATA_W-1:0] port_data
);

  port_state_e       state;
  port_state_e       state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] bus_in;
  logic              bus_oe;
  logic              accept;

  assign accept    = req_valid && req_ready;
  assign port_addr = addr_q;
  assign resp_data = rdata_q;

  reg_port_tbuf #(.W(DATA_W)) u_tbuf (
    .oe   (bus_oe),
    .dout (wdata_q),
    .din  (bus_in),
    .pad  (port_data)
  );

  // State register; reset returns to IDLE at once, which releases the bus.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = state_accepts(state);
    resp_valid = 1'b0;
    port_read  = 1'b1;
    bus_oe     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) state_nxt = req_write ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        port_read = 1'b0;
        bus_oe    = 1'b1;
`ifdef REG_PORT_MASTER_READBACK_EN
        state_nxt = ST_VERIFY;
`else
        if (req_valid) state_nxt = req_write ? ST_WRITE : ST_READ;
        else           state_nxt = ST_IDLE;
`endif
      end
      ST_READ: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
`ifdef REG_PORT_MASTER_READBACK_EN
      ST_VERIFY: begin
        state_nxt = ST_IDLE;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch address and write data of every accepted request.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
      if (req_write) wdata_q <= req_wdata;
    end
  end

  // Capture the file's bus value at the edge that ends the READ cycle.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset)                rdata_q <= '0;
    else if (state == ST_READ) rdata_q <= bus_in;
  end

`ifdef REG_PORT_MASTER_READBACK_EN
  logic wr_err_q;

  // Sticky flag: the value read back after a write differs from what was written.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset)                                       wr_err_q <= 1'b0;
    else if (state == ST_VERIFY && bus_in != wdata_q) wr_err_q <= 1'b1;
  end

  assign wr_err = wr_err_q;
`else
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_port_master.sv
// tb/tb_reg_port_master.sv - scoreboard bench for reg_port_master against a behavioural reg_file port
`timescale 1ns/1ps
module tb_reg_port_master;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk0       = 1'b0;
  logic          reset      = 1'b1;
  logic          req_valid  = 1'b0;
  logic          req_write  = 1'b0;
  logic [AW-1:0] req_addr   = '0;
  logic [DW-1:0] req_wdata  = '0;
  logic          resp_ready = 1'b1;
  logic          force_zero = 1'b0;
  logic          req_ready;
  logic          resp_valid;
  logic          wr_err;
  logic          port_read;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] port_addr;
  wire  [DW-1:0] port_data;

  logic [DW-1:0] file_mem [8];
  logic [DW-1:0] exp_mem  [8];
  logic [DW-1:0] exp_q [$];
  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;

  reg_port_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk0       (clk0),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .wr_err     (wr_err),
    .port_addr  (port_addr),
    .port_read  (port_read),
    .port_data  (port_data)
  );

  always #5 clk0 = ~clk0;

  always @(posedge clk0) cyc <= cyc + 1;

  // Behavioural register file port: drives when read=1, captures when read=0.
  assign port_data = port_read ? (force_zero ? {DW{1'b0}} : file_mem[port_addr]) : {DW{1'bz}};
  always @(posedge clk0) if (!port_read) file_mem[port_addr] <= port_data;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request and return after the edge that accepts it (+1ns).
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int acc_cyc);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && waited < 20) begin
      @(posedge clk0); #1;
      waited++;
    end
    if (!req_ready) check("req_ready_timeout", {15'd0, req_ready}, 16'd1);
    @(posedge clk0); #1;
    acc_cyc = cyc;
    if (wr) exp_mem[a] = d;
    else    exp_q.push_back(exp_mem[a]);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk0);
      waited++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 16'd0);
  endtask

  // Scoreboard monitor: compare each handshaked response with the oldest expectation.
  task automatic monitor();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk0);
      if (!reset && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {15'd0, resp_valid}, 16'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", resp_data, e);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (2) @(negedge clk0);
    check("rst_req_ready",  {15'd0, req_ready},  16'd1);
    check("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
    check("rst_port_read",  {15'd0, port_read},  16'd1);
    check("rst_port_addr",  {13'd0, port_addr},  16'd0);
    check("rst_wr_err",     {15'd0, wr_err},     16'd0);
    check("rst_resp_data",  resp_data,           16'd0);
    @(posedge clk0); #1;
    reset = 1'b0;

    // Back-to-back writes, then reads with response latency check.
    issue(1'b1, 3'd0, 16'hABCD, n);
    @(negedge clk0);
    check("wr0_port_read", {15'd0, port_read}, 16'd0);
    check("wr0_port_addr", {13'd0, port_addr}, 16'd0);
    check("wr0_bus",       port_data,          16'hABCD);
    issue(1'b1, 3'd1, 16'h1234, n);
    @(negedge clk0);
    check("wr1_port_addr", {13'd0, port_addr}, 16'd1);
    check("wr1_bus",       port_data,          16'h1234);
    issue(1'b0, 3'd1, 16'h0000, n);
    idle();
    @(negedge clk0);
    check("rd1_read_valid", {15'd0, resp_valid}, 16'd0);
    check("rd1_read_strobe", {15'd0, port_read}, 16'd1);
    @(negedge clk0);
    check("rd1_resp_valid", {15'd0, resp_valid}, 16'd1);
    issue(1'b0, 3'd0, 16'h0000, n);
    idle();
    drain();

    // Read $7 while the consumer stalls for five cycles.
    issue(1'b1, 3'd7, 16'h7777, n);
    idle();
    resp_ready = 1'b0;
    issue(1'b0, 3'd7, 16'h0000, n);
    idle();
    @(negedge clk0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk0);
      check("hold_resp_valid", {15'd0, resp_valid}, 16'd1);
      check("hold_resp_data",  resp_data,           16'h7777);
      check("hold_req_ready",  {15'd0, req_ready},  16'd0);
      check("hold_port_read",  {15'd0, port_read},  16'd1);
    end
    @(posedge clk0); #1;
    resp_ready = 1'b1;
    @(negedge clk0);
    @(negedge clk0);
    check("hold_done_req_ready",  {15'd0, req_ready},  16'd1);
    check("hold_done_resp_valid", {15'd0, resp_valid}, 16'd0);
    drain();

    // Write immediately followed by a read of the same register.
    issue(1'b1, 3'd2, 16'hBEEF, n);
    issue(1'b0, 3'd2, 16'h0000, n);
    idle();
    @(negedge clk0);
    check("wr_rd_port_read", {15'd0, port_read}, 16'd1);
    check("wr_rd_bus",       port_data,          16'hBEEF);
    drain();

`ifndef REG_PORT_MASTER_READBACK_EN
    // Four writes on four consecutive edges.
    begin : b2b
      int acc [4];
      for (int i = 0; i < 4; i++) issue(1'b1, 3'(i + 4), 16'h1111 * 16'(i + 4), acc[i]);
      idle();
      for (int i = 1; i < 4; i++) check("b2b_gap", 16'(acc[i] - acc[i-1]), 16'd1);
      issue(1'b0, 3'd5, 16'h0000, n);
      idle();
      issue(1'b0, 3'd7, 16'h0000, n);
      idle();
      drain();
      check("wr_err_off", {15'd0, wr_err}, 16'd0);
    end
`endif

    // Reset asserted during WRITE discards the write and releases the bus at once.
    begin : rst_mid
      logic [DW-1:0] keep;
      keep = exp_mem[0];
      issue(1'b1, 3'd0, 16'h0F0F, n);
      idle();
      exp_mem[0] = keep;
      #2;
      reset = 1'b1;
      #1;
      check("midrst_port_read",  {15'd0, port_read},  16'd1);
      check("midrst_resp_valid", {15'd0, resp_valid}, 16'd0);
      check("midrst_bus",        port_data,           keep);
      @(posedge clk0); #1;
      reset = 1'b0;
      @(negedge clk0);
      check("midrst_req_ready", {15'd0, req_ready}, 16'd1);
      issue(1'b0, 3'd0, 16'h0000, n);
      idle();
      drain();
    end

`ifdef REG_PORT_MASTER_READBACK_EN
    // File returns zero after a write of 5A5A: the VERIFY edge sets the sticky flag.
    force_zero = 1'b1;
    issue(1'b1, 3'd3, 16'h5A5A, n);
    idle();
    @(negedge clk0);
    check("verify_pre_err", {15'd0, wr_err}, 16'd0);
    @(negedge clk0);
    check("verify_no_resp", {15'd0, resp_valid}, 16'd0);
    check("verify_strobe",  {15'd0, port_read},  16'd1);
    @(negedge clk0);
    check("verify_err_set", {15'd0, wr_err}, 16'd1);
    force_zero = 1'b0;
    repeat (3) begin
      @(negedge clk0);
      check("verify_err_sticky", {15'd0, wr_err}, 16'd1);
    end
    reset = 1'b1;
    #1;
    check("verify_err_clear", {15'd0, wr_err}, 16'd0);
    @(posedge clk0); #1;
    reset = 1'b0;
`endif

    repeat (3) @(negedge clk0);
    check("final_queue_empty", exp_q.size(), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
